// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - issue/wait/mem/writeback sequencer for IALU, FALU and CORDIC units
// Optional abort of stuck WAIT/MEM phases: define EXEC_TIMEOUT_EN.
module exec_sequencer #(
    parameter int ALUSELECT_WIDTH = 2,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       dec_valid,
    output logic                       dec_ready,
    input  logic [ALUSELECT_WIDTH-1:0] ALUSelect,
    input  logic                       RWE,
    input  logic                       load,
    input  logic                       MWE,
    output logic [2:0]                 unit_start,
    input  logic [2:0]                 unit_done,
    input  logic                       lsu_ack,
    output logic [ALUSELECT_WIDTH-1:0] alu_sel_q,
    output logic                       rf_we,
    output logic                       stall,
    output logic                       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_MEM,
        S_WB
    } state_t;

    if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
        $error("exec_sequencer: TIMEOUT_CYCLES must be at least 2");
    end

    state_t     state_q;
    logic       rwe_q;
    logic       load_q;
    logic       mwe_q;
    logic [2:0] unit_mask_q;
    logic [2:0] unit_start_q;
    logic       rf_we_q;
    logic       err_q;
    logic [2:0] unit_mask_d;
    logic       done_sel;

`ifdef EXEC_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_q;
`endif

    // Reserved select decodes to an empty mask, which is what flags the error.
    always_comb begin
        unit_mask_d = 3'b000;
        if (ALUSelect == ALUSELECT_WIDTH'(0)) begin
            unit_mask_d = 3'b001;
        end else if (ALUSelect == ALUSELECT_WIDTH'(1)) begin
            unit_mask_d = 3'b010;
        end else if (ALUSelect == ALUSELECT_WIDTH'(2)) begin
            unit_mask_d = 3'b100;
        end
    end

    // Masking with the captured unit makes done pulses from other units invisible.
    assign done_sel = |(unit_done & unit_mask_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rwe_q        <= 1'b0;
            load_q       <= 1'b0;
            mwe_q        <= 1'b0;
            unit_mask_q  <= 3'b000;
            unit_start_q <= 3'b000;
            rf_we_q      <= 1'b0;
            err_q        <= 1'b0;
            alu_sel_q    <= '0;
`ifdef EXEC_TIMEOUT_EN
            tmo_q        <= '0;
`endif
        end else begin
            unit_start_q <= 3'b000;
            rf_we_q      <= 1'b0;
            err_q        <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (dec_valid) begin
                        alu_sel_q   <= ALUSelect;
                        rwe_q       <= RWE;
                        load_q      <= load;
                        mwe_q       <= MWE;
                        unit_mask_q <= unit_mask_d;
                        if (unit_mask_d != 3'b000) begin
                            state_q      <= S_ISSUE;
                            unit_start_q <= unit_mask_d;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_ISSUE, S_WAIT: begin
                    if (done_sel) begin
                        if (load_q | mwe_q) begin
                            state_q <= S_MEM;
`ifdef EXEC_TIMEOUT_EN
                            tmo_q   <= '0;
`endif
                        end else begin
                            state_q <= S_WB;
                            rf_we_q <= rwe_q & ~mwe_q;
                        end
                    end else if (state_q == S_ISSUE) begin
                        state_q <= S_WAIT;
`ifdef EXEC_TIMEOUT_EN
                        tmo_q   <= '0;
                    end else if (tmo_q == TMO_LAST) begin
                        state_q <= S_IDLE;
                        err_q   <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
`endif
                    end
                end
                S_MEM: begin
                    if (lsu_ack) begin
                        state_q <= S_WB;
                        rf_we_q <= rwe_q & ~mwe_q;
`ifdef EXEC_TIMEOUT_EN
                    end else if (tmo_q == TMO_LAST) begin
                        state_q <= S_IDLE;
                        err_q   <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
`endif
                    end
                end
                S_WB: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign dec_ready  = (state_q == S_IDLE);
    assign stall      = (state_q != S_IDLE);
    assign unit_start = unit_start_q;
    assign rf_we      = rf_we_q;
    assign err        = err_q;

endmodule
